// File: rtl/load_use_scoreboard_pkg.sv
// Shared constants and helpers for the load-use hazard scoreboard.
package load_use_scoreboard_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;
  localparam int unsigned XZR_IDX        = 31;

  // Countdown width able to hold the value LOAD_LAT.
  function automatic int unsigned lat_w(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/load_use_scoreboard_if.sv
// ID-stage hazard bus: decoded instruction fields in, stall/status out.
interface load_use_scoreboard_if #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned PERF_W     = 32
);
  logic                  id_valid;
  logic [REG_ADDR_W-1:0] id_rn;
  logic [REG_ADDR_W-1:0] id_rm;
  logic                  id_rn_used;
  logic                  id_rm_used;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  id_reg_write;
  logic                  id_mem_read;
  logic                  id_flush;
  logic                  stall;
  logic                  pc_stall;
  logic                  pending_any;
  logic [PERF_W-1:0]     stall_cycles;

  modport master (
    output id_valid, id_rn, id_rm, id_rn_used, id_rm_used, id_rd, id_reg_write, id_mem_read,
           id_flush,
    input  stall, pc_stall, pending_any, stall_cycles
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_rn_used, id_rm_used, id_rd, id_reg_write, id_mem_read,
           id_flush,
    output stall, pc_stall, pending_any, stall_cycles
  );
endinterface

// File: rtl/load_use_scoreboard_sb_entry.sv
// One scoreboard entry: countdown of cycles until a pending load's data is forwardable.
module load_use_scoreboard_sb_entry
  import load_use_scoreboard_pkg::*;
#(
  parameter int unsigned LOAD_LAT = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_load,
  input  logic i_clear,
  output logic o_busy
);

  localparam int unsigned CNT_W = lat_w(LOAD_LAT);

  logic [CNT_W-1:0] r_cnt;

  // A reload wins over a clear; a younger ALU write makes the load result irrelevant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= CNT_W'(LOAD_LAT);
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/load_use_scoreboard.sv
// Multi-cycle load-use stall logic: per-register countdowns gate dependants in ID.
module load_use_scoreboard
  import load_use_scoreboard_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = REG_ADDR_W_DEF,
  parameter int unsigned NUM_REGS     = 32,
  parameter int unsigned LOAD_LAT     = 1,
  parameter int unsigned ZERO_REG     = XZR_IDX,
  parameter int unsigned HAS_ZERO_REG = 1,
  parameter int unsigned PERF_W       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  load_use_scoreboard_if.slave  id_bus
);

  localparam int unsigned NUM_IDX = 2 ** REG_ADDR_W;

  logic [NUM_REGS-1:0] w_busy;
  logic [NUM_IDX-1:0]  w_busy_idx;
  logic                w_rn_zero;
  logic                w_rm_zero;
  logic                w_rd_zero;
  logic                w_rn_hz;
  logic                w_rm_hz;
  logic                w_live;
  logic                w_stall;
  logic                w_issue;
  logic [PERF_W-1:0]   r_stall_cycles;

  // Zero-extended so indices at or above NUM_REGS read as never busy.
  assign w_busy_idx = NUM_IDX'(w_busy);

  assign w_rn_zero = (HAS_ZERO_REG != 0) && (id_bus.id_rn == REG_ADDR_W'(ZERO_REG));
  assign w_rm_zero = (HAS_ZERO_REG != 0) && (id_bus.id_rm == REG_ADDR_W'(ZERO_REG));
  assign w_rd_zero = (HAS_ZERO_REG != 0) && (id_bus.id_rd == REG_ADDR_W'(ZERO_REG));

  assign w_rn_hz = id_bus.id_rn_used && w_busy_idx[id_bus.id_rn] && !w_rn_zero;
  assign w_rm_hz = id_bus.id_rm_used && w_busy_idx[id_bus.id_rm] && !w_rm_zero;

  assign w_live  = id_bus.id_valid && !id_bus.id_flush;
  assign w_stall = w_live && (w_rn_hz || w_rm_hz);
  assign w_issue = w_live && !w_stall && id_bus.id_reg_write && !w_rd_zero;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_entry
    logic w_hit;
    assign w_hit = w_issue && (id_bus.id_rd == REG_ADDR_W'(g));

    load_use_scoreboard_sb_entry #(
      .LOAD_LAT (LOAD_LAT)
    ) u_entry (
      .clk     (clk),
      .reset   (reset),
      .i_load  (w_hit && id_bus.id_mem_read),
      .i_clear (w_hit && !id_bus.id_mem_read),
      .o_busy  (w_busy[g])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= '0;
    end else if (w_stall && (r_stall_cycles != {PERF_W{1'b1}})) begin
      r_stall_cycles <= r_stall_cycles + PERF_W'(1);
    end
  end

  assign id_bus.stall        = w_stall;
  assign id_bus.pc_stall     = w_stall;
  assign id_bus.pending_any  = |w_busy;
  assign id_bus.stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_load_use_scoreboard.sv
// Four scoreboard configurations share one ID stimulus stream and are checked against a
// ready-time model every cycle, plus directed literal expectations.
module tb_load_use_scoreboard;

  typedef struct packed {
    logic       valid;
    logic [4:0] rn;
    logic       rn_used;
    logic [4:0] rm;
    logic       rm_used;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
    logic       flush;
  } id_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  id_t  s = '0;
  bit   chk_en = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  load_use_scoreboard_if #(.REG_ADDR_W(5), .PERF_W(32)) bus0 ();
  load_use_scoreboard_if #(.REG_ADDR_W(5), .PERF_W(32)) bus1 ();
  load_use_scoreboard_if #(.REG_ADDR_W(5), .PERF_W(32)) bus2 ();
  load_use_scoreboard_if #(.REG_ADDR_W(5), .PERF_W(4))  bus3 ();

  assign {bus0.id_valid, bus0.id_rn, bus0.id_rn_used, bus0.id_rm, bus0.id_rm_used, bus0.id_rd,
          bus0.id_reg_write, bus0.id_mem_read, bus0.id_flush} = s;
  assign {bus1.id_valid, bus1.id_rn, bus1.id_rn_used, bus1.id_rm, bus1.id_rm_used, bus1.id_rd,
          bus1.id_reg_write, bus1.id_mem_read, bus1.id_flush} = s;
  assign {bus2.id_valid, bus2.id_rn, bus2.id_rn_used, bus2.id_rm, bus2.id_rm_used, bus2.id_rd,
          bus2.id_reg_write, bus2.id_mem_read, bus2.id_flush} = s;
  assign {bus3.id_valid, bus3.id_rn, bus3.id_rn_used, bus3.id_rm, bus3.id_rm_used, bus3.id_rd,
          bus3.id_reg_write, bus3.id_mem_read, bus3.id_flush} = s;

  load_use_scoreboard #(.REG_ADDR_W(5), .NUM_REGS(32), .LOAD_LAT(1), .ZERO_REG(31),
                        .HAS_ZERO_REG(1), .PERF_W(32))
    dut0 (.clk(clk), .reset(reset), .id_bus(bus0));
  load_use_scoreboard #(.REG_ADDR_W(5), .NUM_REGS(32), .LOAD_LAT(3), .ZERO_REG(31),
                        .HAS_ZERO_REG(1), .PERF_W(32))
    dut1 (.clk(clk), .reset(reset), .id_bus(bus1));
  load_use_scoreboard #(.REG_ADDR_W(5), .NUM_REGS(32), .LOAD_LAT(3), .ZERO_REG(31),
                        .HAS_ZERO_REG(0), .PERF_W(32))
    dut2 (.clk(clk), .reset(reset), .id_bus(bus2));
  load_use_scoreboard #(.REG_ADDR_W(5), .NUM_REGS(24), .LOAD_LAT(3), .ZERO_REG(31),
                        .HAS_ZERO_REG(1), .PERF_W(4))
    dut3 (.clk(clk), .reset(reset), .id_bus(bus3));

  logic [3:0]  d_stall, d_pc, d_pend;
  logic [31:0] d_cnt [4];

  assign {d_stall[0], d_pc[0], d_pend[0]} = {bus0.stall, bus0.pc_stall, bus0.pending_any};
  assign {d_stall[1], d_pc[1], d_pend[1]} = {bus1.stall, bus1.pc_stall, bus1.pending_any};
  assign {d_stall[2], d_pc[2], d_pend[2]} = {bus2.stall, bus2.pc_stall, bus2.pending_any};
  assign {d_stall[3], d_pc[3], d_pend[3]} = {bus3.stall, bus3.pc_stall, bus3.pending_any};
  assign d_cnt[0] = bus0.stall_cycles;
  assign d_cnt[1] = bus1.stall_cycles;
  assign d_cnt[2] = bus2.stall_cycles;
  assign d_cnt[3] = 32'(bus3.stall_cycles);

  // Model: each register remembers the cycle its load data becomes forwardable.
  int     cyc = 0;
  int     ready [4][32];
  longint mcnt [4];

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction
  function automatic bit hzr_of(input int k);
    return k != 2;
  endfunction
  function automatic int nregs_of(input int k);
    return (k == 3) ? 24 : 32;
  endfunction
  function automatic longint pmax_of(input int k);
    return (k == 3) ? 64'd15 : 64'hFFFF_FFFF;
  endfunction

  function automatic bit m_hz(input int k, input logic [4:0] x, input logic used);
    return used && (int'(x) < nregs_of(k)) && (ready[k][x] > cyc) && !(hzr_of(k) && x == 5'd31);
  endfunction
  function automatic bit m_stall(input int k);
    return s.valid && !s.flush && (m_hz(k, s.rn, s.rn_used) || m_hz(k, s.rm, s.rm_used));
  endfunction
  function automatic bit m_pend(input int k);
    for (int r = 0; r < 32; r++) if (ready[k][r] > cyc) return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (reset) begin
        for (int r = 0; r < 32; r++) ready[k][r] = 0;
        mcnt[k] = 0;
      end else begin
        bit st, iss;
        st  = m_stall(k);
        iss = s.valid && !s.flush && !st && s.rw && !(hzr_of(k) && s.rd == 5'd31);
        if (st && mcnt[k] < pmax_of(k)) mcnt[k]++;
        if (iss && int'(s.rd) < nregs_of(k)) ready[k][s.rd] = s.mr ? cyc + 1 + lat_of(k) : 0;
      end
    end
    cyc++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 4; k++) begin
        check($sformatf("cfg%0d stall", k), 32'(d_stall[k]), 32'(m_stall(k)));
        check($sformatf("cfg%0d pc_stall", k), 32'(d_pc[k]), 32'(m_stall(k)));
        check($sformatf("cfg%0d pending_any", k), 32'(d_pend[k]), 32'(m_pend(k)));
        check($sformatf("cfg%0d stall_cycles", k), d_cnt[k], 32'(mcnt[k]));
      end
    end
  end

  function automatic id_t nop();
    return '0;
  endfunction
  function automatic id_t ldur(input logic [4:0] rd, input logic [4:0] rn);
    id_t v = '0;
    v.valid = 1'b1; v.rn = rn; v.rn_used = 1'b1; v.rd = rd; v.rw = 1'b1; v.mr = 1'b1;
    return v;
  endfunction
  function automatic id_t alu(input logic [4:0] rd, input logic [4:0] rn, input logic [4:0] rm);
    id_t v = '0;
    v.valid = 1'b1; v.rn = rn; v.rn_used = 1'b1; v.rm = rm; v.rm_used = 1'b1;
    v.rd = rd; v.rw = 1'b1;
    return v;
  endfunction

  // Apply one ID-stage cycle; returns shortly after the following negedge.
  task automatic step(input logic rst, input id_t v);
    @(posedge clk);
    #1;
    reset = rst;
    s = v;
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1'b0, nop());
  endtask

  initial begin
    id_t t;
    step(1'b1, nop());
    step(1'b1, nop());
    check("reset stall", 32'(d_stall[1]), 32'd0);
    check("reset pending", 32'(d_pend[1]), 32'd0);
    check("reset stall_cycles", d_cnt[1], 32'd0);
    chk_en = 1'b1;

    // LAT=1 classic bubble
    step(1'b0, ldur(5'd2, 5'd1));
    check("s1 no stall on load", 32'(d_stall[0]), 32'd0);
    step(1'b0, alu(5'd3, 5'd2, 5'd4));
    check("s1 stall", 32'(d_stall[0]), 32'd1);
    check("s1 pc_stall", 32'(d_pc[0]), 32'd1);
    step(1'b0, alu(5'd3, 5'd2, 5'd4));
    check("s1 released", 32'(d_stall[0]), 32'd0);
    check("s1 stall_cycles", d_cnt[0], 32'd1);
    drain();

    // LAT=3 dependant through Rm
    step(1'b0, ldur(5'd5, 5'd1));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, alu(5'd8, 5'd1, 5'd5));
      check($sformatf("s2 stall c%0d", i), 32'(d_stall[1]), (i < 3) ? 32'd1 : 32'd0);
    end
    check("s2 stall_cycles", d_cnt[1], 32'd5);
    step(1'b0, ldur(5'd5, 5'd1));
    step(1'b0, alu(5'd9, 5'd6, 5'd6));
    check("s2 unrelated", 32'(d_stall[1]), 32'd0);
    check("s2 pending", 32'(d_pend[1]), 32'd1);
    drain();

    // zero register exemption
    step(1'b0, ldur(5'd31, 5'd1));
    for (int i = 0; i < 4; i++) begin
      step(1'b0, alu(5'd9, 5'd31, 5'd31));
      check($sformatf("s3 xzr c%0d", i), 32'(d_stall[1]), 32'd0);
      check($sformatf("s3 no-xzr c%0d", i), 32'(d_stall[2]), (i < 3) ? 32'd1 : 32'd0);
    end
    drain();

    // younger ALU write supersedes the load
    step(1'b0, ldur(5'd7, 5'd1));
    step(1'b0, alu(5'd7, 5'd1, 5'd2));
    step(1'b0, alu(5'd10, 5'd7, 5'd7));
    check("s4 no stall", 32'(d_stall[1]), 32'd0);
    check("s4 no pending", 32'(d_pend[1]), 32'd0);
    drain();

    // flush and unused source
    step(1'b0, ldur(5'd12, 5'd1));
    t = alu(5'd13, 5'd12, 5'd1);
    t.flush = 1'b1;
    step(1'b0, t);
    check("s5 flushed", 32'(d_stall[1]), 32'd0);
    t = alu(5'd13, 5'd12, 5'd1);
    t.rn_used = 1'b0;
    step(1'b0, t);
    check("s5 rn unused", 32'(d_stall[1]), 32'd0);
    t = ldur(5'd14, 5'd1);
    t.flush = 1'b1;
    step(1'b0, t);
    step(1'b0, alu(5'd15, 5'd14, 5'd14));
    check("s5 flushed load", 32'(d_stall[1]), 32'd0);
    drain();

    // destination beyond NUM_REGS is not tracked
    step(1'b0, ldur(5'd26, 5'd1));
    step(1'b0, alu(5'd15, 5'd26, 5'd0));
    check("s5 rd>=NUM_REGS", 32'(d_stall[3]), 32'd0);
    check("s5 rd<NUM_REGS", 32'(d_stall[1]), 32'd1);
    drain();

    // reset during the second stall cycle
    step(1'b0, ldur(5'd5, 5'd1));
    step(1'b0, alu(5'd8, 5'd1, 5'd5));
    step(1'b1, alu(5'd8, 5'd1, 5'd5));
    step(1'b0, alu(5'd8, 5'd1, 5'd5));
    check("s6 stall after reset", 32'(d_stall[1]), 32'd0);
    check("s6 pending after reset", 32'(d_pend[1]), 32'd0);
    check("s6 stall_cycles after reset", d_cnt[1], 32'd0);

    // perf counter saturation: 7 x 3 stall cycles
    for (int n = 0; n < 7; n++) begin
      step(1'b0, ldur(5'd5, 5'd1));
      for (int i = 0; i < 4; i++) step(1'b0, alu(5'd8, 5'd1, 5'd5));
    end
    drain();
    check("s6 lat1 count", d_cnt[0], 32'd7);
    check("s6 lat3 count", d_cnt[1], 32'd21);
    check("s6 saturated", d_cnt[3], 32'd15);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
